// File: rtl/a_path_pkg.sv
// Shared A-operand path types: FSM state encoding and the A word width.
// Used by the deserializer front end and by the A register.
package a_path_pkg;

    localparam int A_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/a_deserializer_shift_in_reg.sv
// WIDTH-bit serial-in shift register with clear, enable and running even parity.
// Latency: one edge per accepted bit; no backpressure, shifts whenever en is high.
module shift_in_reg
    import a_path_pkg::*;
#(
    parameter int WIDTH     = A_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt,
    output logic             par
);

    logic [WIDTH-1:0] q_r;

    // nxt is the value the register takes if din is accepted this cycle
    generate
        if (MSB_FIRST) begin : g_msb
            assign nxt = {q_r[WIDTH-2:0], din};
        end else begin : g_lsb
            assign nxt = {din, q_r[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_r <= '0;
        end else if (en) begin
            q_r <= nxt;
        end
    end

    assign q   = q_r;
    assign par = ^q_r;

endmodule

// File: rtl/a_deserializer.sv
// Framed serial-to-parallel front end for the A operand; optional even parity via A_DESER_PARITY_EN.
// Latency: load/err one cycle after the last accepted bit; no backpressure, bit_valid low simply stalls.
module a_deserializer
    import a_path_pkg::*;
#(
    parameter int WIDTH     = A_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic [WIDTH-1:0] data_out,
    output logic             load,
    output logic             busy,
    output logic             err
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             err_q, err_d;

    logic             sr_clr, sr_en;
    logic [WIDTH-1:0] sr_q, sr_nxt, sr_word;
    logic             sr_par;
    logic             sr_unused;

    shift_in_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sr (
        .clk (clk),
        .rst (rst),
        .clr (sr_clr),
        .en  (sr_en),
        .din (bit_in),
        .q   (sr_q),
        .nxt (sr_nxt),
        .par (sr_par)
    );

    // Word handed to data_out: the completed register after parity, or the
    // register including the bit being accepted when there is no parity phase.
`ifdef A_DESER_PARITY_EN
    assign sr_word   = sr_q;
    assign sr_unused = ^sr_nxt;
`else
    assign sr_word   = sr_nxt;
    assign sr_unused = ^{sr_q, sr_par};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        sr_clr  = 1'b0;
        sr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sr_clr  = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (frame_start) begin
                    // abort: restart the frame, the same-cycle bit is dropped
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sr_clr  = 1'b1;
                end else if (bit_valid) begin
                    sr_en = 1'b1;
                    if (cnt_q == LAST) begin
`ifdef A_DESER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
                        load_d  = 1'b1;
                        data_d  = sr_word;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

`ifdef A_DESER_PARITY_EN
            ST_PARITY: begin
                if (frame_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sr_clr  = 1'b1;
                end else if (bit_valid) begin
                    if (sr_par ^ bit_in) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                        load_d  = 1'b1;
                        data_d  = sr_word;
                    end
                end
            end
`endif

            ST_DONE: begin
                if (frame_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sr_clr  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign data_out = data_q;
    assign load     = load_q;
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

endmodule
